// File: rtl/deser_pkg.sv
// Shared deserializer definitions: FSM state encoding, default sync pattern
// and the serial bit-order convention agreed with the serializer.
package deser_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hBC;

    // First bit on the wire is word bit 0.
    localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/deser8_sipo_shreg.sv
// Serial-in parallel-out window register fed in the link bit order.
// Latency: dout reflects din one cycle after a shift; clear wins over shift.
// Backpressure: none, shifts whenever shift is high.
module sipo_shreg
    import deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift,
    input  logic             clear,
    input  logic             din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (clear) begin
            dout <= '0;
        end else if (shift) begin
            dout <= LSB_FIRST ? {din, dout[WIDTH-1:1]} : {dout[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/deser8.sv
// Sync-word aligned serial-to-parallel deserializer, LSB-first input.
// Latency: word_valid one cycle after the strobe edge of a word's last bit.
// Backpressure: none; consumer must take every word_valid pulse.
module deser8
    import deser_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(SYNC_DEFAULT),
    localparam int             CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             align,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             word_is_sync,
    output logic             locked,
    output logic [CNT_W-1:0] bit_cnt
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   window;
    logic [WIDTH-1:0]   shifted;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [WIDTH-1:0]   word_nxt;
    logic               wv_nxt, ws_nxt;
    logic               shift, clear;

    sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (shift),
        .clear (clear),
        .din   (bit_in),
        .dout  (window)
    );

    // Window contents as they will be after this bit is shifted in.
    assign shifted = LSB_FIRST ? {bit_in, window[WIDTH-1:1]} : {window[WIDTH-2:0], bit_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            bit_cnt      <= '0;
            word_out     <= '0;
            word_valid   <= 1'b0;
            word_is_sync <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= cnt_nxt;
            word_out     <= word_nxt;
            word_valid   <= wv_nxt;
            word_is_sync <= ws_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        word_nxt  = word_out;
        wv_nxt    = 1'b0;
        ws_nxt    = 1'b0;
        shift     = 1'b0;
        clear     = 1'b0;
        if (align) begin
            // Resync drops any strobe in the same cycle; word_out is kept.
            state_nxt = HUNT;
            cnt_nxt   = '0;
            clear     = 1'b1;
        end else if (bit_valid) begin
            shift = 1'b1;
            case (state)
                HUNT: begin
                    cnt_nxt = '0;
                    if (shifted == SYNC_WORD) begin
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        word_nxt = shifted;
                        wv_nxt   = 1'b1;
                        ws_nxt   = (shifted == SYNC_WORD);
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_deser8.sv
// Directed bench for deser8 with an expected-word queue checked by a monitor.
module tb_deser8;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       bit_valid;
    logic       align;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_is_sync;
    logic       locked;
    logic [2:0] bit_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // {is_sync, data}
    logic [8:0] exp_q[$];
    logic       prev_wv;

    deser8 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .align        (align),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_is_sync (word_is_sync),
        .locked       (locked),
        .bit_cnt      (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every word_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wv = 1'b0;
        end else begin
            if (word_valid) begin
                if (prev_wv) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wv_back_to_back: word_valid high two cycles in a row");
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h sync=%0b, expected no word", word_out, word_is_sync);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("word_out", {24'd0, word_out}, {24'd0, e[7:0]});
                    chk("word_is_sync", {31'd0, word_is_sync}, {31'd0, e[8]});
                end
            end
            prev_wv = word_valid;
        end
    end

    // Presents one bit for exactly one rising edge; leaves bit_valid high.
    task automatic push(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] w, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            push(w[i]);
            if (gap > 0) idle(gap);
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        align     = 1'b0;
        prev_wv   = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_word_out", {24'd0, word_out}, 32'h00);
        chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_word_is_sync", {31'd0, word_is_sync}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_bit_cnt", {29'd0, bit_cnt}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: sync word locks, no word emitted
        send_bits(8'hBC, 8, 0);
        chk("t1_locked", {31'd0, locked}, 32'd1);
        chk("t1_bit_cnt", {29'd0, bit_cnt}, 32'd0);
        idle(2);

        // 2: first data word, back-to-back bits
        exp_q.push_back({1'b0, 8'hAA});
        send_bits(8'hAA, 8, 0);
        idle(2);
        chk("t2_bit_cnt", {29'd0, bit_cnt}, 32'd0);

        // 3: strobed every third cycle; counter only moves on strobes
        exp_q.push_back({1'b1, 8'hBC});
        send_bits(8'hBC, 3, 2);
        chk("t3_bit_cnt_mid", {29'd0, bit_cnt}, 32'd3);
        idle(4);
        chk("t3_bit_cnt_hold", {29'd0, bit_cnt}, 32'd3);
        send_bits(8'hBC >> 3, 5, 2);
        exp_q.push_back({1'b0, 8'h55});
        send_bits(8'h55, 8, 2);
        idle(2);
        chk("t3_locked", {31'd0, locked}, 32'd1);

        // 4: resync, then preamble 1,1,0 before the sync word
        align = 1'b1;
        @(negedge clk);
        align = 1'b0;
        chk("t4_unlocked", {31'd0, locked}, 32'd0);
        chk("t4_word_out_kept", {24'd0, word_out}, 32'h55);
        send_bits(8'b011, 3, 0);
        send_bits(8'hBC, 8, 0);
        chk("t4_locked", {31'd0, locked}, 32'd1);
        exp_q.push_back({1'b0, 8'hAA});
        send_bits(8'hAA, 8, 0);
        idle(2);

        // 5: align together with a strobe at bit_cnt=5
        send_bits(8'hFF, 5, 0);
        chk("t5_bit_cnt", {29'd0, bit_cnt}, 32'd5);
        align     = 1'b1;
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        @(negedge clk);
        align     = 1'b0;
        bit_valid = 1'b0;
        chk("t5_locked", {31'd0, locked}, 32'd0);
        chk("t5_bit_cnt_clr", {29'd0, bit_cnt}, 32'd0);
        chk("t5_word_out_kept", {24'd0, word_out}, 32'hAA);
        send_bits(8'h11, 8, 0);
        send_bits(8'h11, 8, 0);
        chk("t5_still_hunting", {31'd0, locked}, 32'd0);
        send_bits(8'hBC, 8, 0);
        chk("t5_relocked", {31'd0, locked}, 32'd1);

        // 6: asynchronous reset in mid-word
        send_bits(8'h0F, 3, 0);
        chk("t6_bit_cnt", {29'd0, bit_cnt}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_word_out", {24'd0, word_out}, 32'h00);
        chk("t6_locked", {31'd0, locked}, 32'd0);
        chk("t6_bit_cnt_clr", {29'd0, bit_cnt}, 32'd0);
        chk("t6_word_valid", {31'd0, word_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send_bits(8'hBC, 8, 0);
        chk("t6_relocked", {31'd0, locked}, 32'd1);
        exp_q.push_back({1'b0, 8'h33});
        send_bits(8'h33, 8, 0);
        idle(3);

        chk("pending_words", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/deser8.md
Name: deser8

Overview:
Serial-to-parallel deserializer for the receive side of the link. It consumes the LSB-first bit stream produced by the mux8-based serializer, after CDR recovery, and finds word alignment by hunting for a sync word. Once aligned, it emits one parallel word every WIDTH accepted bits. It sits between the CDR bit-recovery logic and the downstream word consumer.

Parameters:
WIDTH, 8, word width in bits; must be a power of two, ≥ 4.
SYNC_WORD, 8'hBC, alignment pattern in parallel LSB-first form; width WIDTH.
CNT_W, $clog2(WIDTH), derived localparam, not overridable; bit counter width.

Ports:
clk  input  1  rising-edge system clock
rst_n  input  1  asynchronous active-low reset
bit_in  input  1  recovered serial data bit
bit_valid  input  1  strobe, one cycle per recovered bit; bit_in is sampled only when high
align  input  1  synchronous resync request; forces return to HUNT
word_out  output  WIDTH  last assembled word; bit received first is at index 0
word_valid  output  1  one-cycle pulse when word_out updates
word_is_sync  output  1  qualifies word_valid; high when word_out == SYNC_WORD
locked  output  1  high while in LOCKED state
bit_cnt  output  CNT_W  bit position of the next accepted bit within the current word

Behaviour:
- Reset (rst_n low, asynchronous): state=HUNT; window=0; bit_cnt=0; word_out=0; word_valid=0; word_is_sync=0; locked=0.
- Accepted bit: bit_valid=1 on a rising edge. Shift rule: window <= {bit_in, window[WIDTH-1:1]}. This makes the bit that arrived first land at index 0 after WIDTH shifts.
- word_valid and word_is_sync default to 0 every cycle; they are never high for two consecutive cycles.
- State HUNT:
  - Every accepted bit shifts into window. bit_cnt stays 0.
  - If the post-shift value {bit_in, window[WIDTH-1:1]} == SYNC_WORD: state <= LOCKED, locked <= 1, bit_cnt <= 0.
  - The sync word found in HUNT is not output; word_valid stays 0.
- State LOCKED:
  - Every accepted bit shifts into window and increments bit_cnt, wrapping WIDTH-1 -> 0.
  - On the accepted bit with bit_cnt == WIDTH-1: word_out <= post-shift window; word_valid <= 1; word_is_sync <= (post-shift window == SYNC_WORD).
  - word_out, word_valid and word_is_sync are all visible in the cycle after that edge. Latency from the last bit's strobe edge to word_valid is 1 cycle.
  - word_out holds its value until the next word completes.
  - No automatic loss-of-lock; only align or reset leaves LOCKED.
- align=1 (any state), evaluated at a rising edge:
  - state <= HUNT; locked <= 0; bit_cnt <= 0; window <= 0; word_valid <= 0.
  - word_out keeps its last value.
  - align has priority over a simultaneous bit_valid; that bit is discarded.
- bit_valid low: no state change; gaps of any length between bits are legal.
- Reset asserted mid-word: the partial word is discarded and all outputs are cleared immediately. After deassertion the block starts in HUNT.
- Back-to-back bit_valid every cycle is supported: one word every WIDTH cycles, no dead cycles.

Decomposition:
- Package deser_pkg:
  - state enum {HUNT, LOCKED} (1-bit encoding);
  - default sync constant SYNC_DEFAULT = 8'hBC;
  - LSB-first bit-order convention constant, shared with the serializer side.
- Sub-module sipo_shreg (WIDTH):
  - ports: shift enable, clear, serial in, parallel out;
  - holds window.
- deser8 contains the FSM, bit counter and output registers.

Test Plan:
1. Reset, then feed bits 0,0,1,1,1,1,0,1 (0xBC LSB-first) with bit_valid every cycle -> locked=1 one cycle after the 8th bit, word_valid stays 0, bit_cnt=0.
2. After lock, feed 0,1,0,1,0,1,0,1 -> word_valid pulses once, 1 cycle after the 8th bit; word_out=8'hAA; word_is_sync=0.
3. After lock, feed 0xBC again, then 0x55, with bit_valid every 3rd cycle -> two pulses: 8'hBC with word_is_sync=1, then 8'h55 with word_is_sync=0. bit_cnt advances only on strobes.
4. Arbitrary preamble 1,1,0 then 0xBC then 0xAA -> no output before lock. First word_valid carries 8'hAA, i.e. alignment slides correctly.
5. Assert align while LOCKED with bit_cnt=5, and bit_valid=1 in the same cycle -> next cycle locked=0, bit_cnt=0, that bit is dropped, word_out is unchanged. A 0x11 stream produces no word_valid until 0xBC is seen.
6. Drop rst_n mid-word (bit_cnt=3) between clock edges -> all outputs 0 immediately without a clock edge. After release the block relocks on 0xBC.
